// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch/decode front-end sequencing controller.
//   ctrlState_t : controller state (RUN, WAIT, FLUSH)
//   PC_SEL_*    : encodings of the 3-input next-PC mux select
//   ctrlOut_t   : bundle of the per-cycle control outputs
//   CTRL_RESET  : control output values while reset is asserted
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } ctrlState_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;  // PC+4
  localparam logic [1:0] PC_SEL_BR  = 2'd1;  // branch target (resolved in EX)
  localparam logic [1:0] PC_SEL_JMP = 2'd2;  // jump target (resolved in ID)

  typedef struct packed {
    logic [1:0] pcSel;
    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexFlush;
  } ctrlOut_t;

  // Pipeline frozen and both bubble inserts active while in reset.
  localparam ctrlOut_t CTRL_RESET = '{
    pcSel:     PC_SEL_SEQ,
    pcWrite:   1'b0,
    ifidWrite: 1'b0,
    ifidFlush: 1'b1,
    idexFlush: 1'b1
  };

endpackage

// File: rtl/pc_redirect_ctrl_load_use_detect.sv
// Load-use hazard compare: flags an instruction in ID that reads the destination of a
// load currently in EX. Register 0 is hard-wired, so a load targeting it never stalls.
// Ports:
//   exMemread  in  EX holds a load
//   exRd       in  destination register of the EX instruction
//   idRs       in  rs field of the ID instruction
//   idRt       in  rt field of the ID instruction
//   idUsesRt   in  ID instruction actually reads rt
//   loadUse    out hazard present this cycle
module pc_redirect_ctrl_load_use_detect (
  input  logic       exMemread,
  input  logic [4:0] exRd,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  output logic       loadUse
);

  logic rsHit;
  logic rtHit;

  assign rsHit   = (exRd == idRs);
  assign rtHit   = idUsesRt && (exRd == idRt);
  assign loadUse = exMemread && (exRd != 5'd0) && (rsHit || rtHit);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Pipeline sequencing controller for the fetch/decode front end.
// Drives the next-PC mux select and the PC / IF-ID / ID-EX write and flush controls for
// load-use stalls, taken branches (EX), jumps (ID) and instruction-memory wait states.
// A redirect that arrives during a wait state is held until the fetch completes.
// Parameters:
//   FLUSH_CYCLES  cycles ifid_flush stays high once a redirect is accepted (1..7)
//   CNT_W         width of the saturating stall-cycle counter
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   imem_ready            fetch returns this cycle (0 = wait state)
//   id_rs, id_rt          source fields of the ID instruction
//   id_uses_rt            ID instruction reads rt
//   id_jump               ID holds a jump
//   ex_memread, ex_rd     EX holds a load and its destination
//   ex_branch_taken       EX branch resolved taken
//   pc_sel                next-PC select (0 PC+4, 1 branch, 2 jump)
//   pc_write, ifid_write  PC and IF/ID load enables
//   ifid_flush            bubble into IF/ID
//   idex_flush            bubble into ID/EX control
//   stall_count           saturating count of cycles with pc_write=0
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  output logic [1:0]       pc_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_count
);

  import pc_redirect_ctrl_pkg::*;

  // Remaining FLUSH cycles after the accepting cycle itself.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  ctrlState_t       state;
  ctrlState_t       stateNext;
  logic [1:0]       pendSel;
  logic [1:0]       pendSelNext;
  logic [2:0]       flushCnt;
  logic [2:0]       flushCntNext;
  logic [CNT_W-1:0] stallCount;
  ctrlOut_t         ctrl;

  logic       loadUse;
  logic       evBr;
  logic       evJmp;
  logic       evLu;
  logic [1:0] redirSel;

  pc_redirect_ctrl_load_use_detect u_load_use_detect (
    .exMemread (ex_memread),
    .exRd      (ex_rd),
    .idRs      (id_rs),
    .idRt      (id_rt),
    .idUsesRt  (id_uses_rt),
    .loadUse   (loadUse)
  );

  // Event priority: branch over jump over load-use. A branch squashes a simultaneous
  // jump in ID, and its ID/EX flush also removes the instruction that would have stalled.
  assign evBr     = ex_branch_taken;
  assign evJmp    = id_jump && !ex_branch_taken;
  assign evLu     = loadUse && !evBr && !evJmp;
  assign redirSel = evBr ? PC_SEL_BR : PC_SEL_JMP;

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    ctrl         = '{pcSel: PC_SEL_SEQ, pcWrite: 1'b0, ifidWrite: 1'b0,
                     ifidFlush: 1'b0, idexFlush: 1'b0};
    stateNext    = state;
    pendSelNext  = pendSel;
    flushCntNext = flushCnt;

    unique case (state)
      RUN: begin
        if (evBr || evJmp) begin
          ctrl.pcSel = redirSel;
          if (imem_ready) begin
            // Redirect accepted: load the target, bubble the wrong-path fetch. A jump
            // continues into EX, a branch kills whatever sits in ID.
            ctrl.pcWrite   = 1'b1;
            ctrl.ifidWrite = 1'b1;
            ctrl.ifidFlush = 1'b1;
            ctrl.idexFlush = evBr;
            stateNext      = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            flushCntNext   = FLUSH_INIT;
          end else begin
            // Fetch not back yet: freeze and remember where to go.
            ctrl.idexFlush = 1'b1;
            pendSelNext    = redirSel;
            stateNext      = WAIT;
          end
        end else if (evLu) begin
          // Single bubble: next cycle the load has left EX, so this cannot repeat.
          ctrl.idexFlush = 1'b1;
        end else begin
          ctrl.pcWrite   = imem_ready;
          ctrl.ifidWrite = imem_ready;
          ctrl.idexFlush = !imem_ready;
        end
      end

      WAIT: begin
        // Pipeline frozen with a bubble in EX; new events cannot be real.
        ctrl.pcSel     = pendSel;
        ctrl.pcWrite   = imem_ready;
        ctrl.idexFlush = 1'b1;
        if (imem_ready) begin
          ctrl.ifidFlush = 1'b1;
          pendSelNext    = PC_SEL_SEQ;
          stateNext      = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
          flushCntNext   = FLUSH_INIT;
        end
      end

      FLUSH: begin
        // Fetches still on the wrong path; keep bubbling and ignore their events.
        ctrl.pcWrite   = imem_ready;
        ctrl.ifidWrite = imem_ready;
        ctrl.ifidFlush = 1'b1;
        ctrl.idexFlush = 1'b1;
        if (imem_ready) begin
          flushCntNext = flushCnt - 3'd1;
          if (flushCnt <= 3'd1) begin
            flushCntNext = 3'd0;
            stateNext    = RUN;
          end
        end
      end

      default: stateNext = RUN;
    endcase

    // Outputs follow reset immediately, not at the next clock.
    if (!reset_n) begin
      ctrl = CTRL_RESET;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      pendSel  <= PC_SEL_SEQ;
      flushCnt <= 3'd0;
    end else begin
      state    <= stateNext;
      pendSel  <= pendSelNext;
      flushCnt <= flushCntNext;
    end
  end

  // NOTE: the counter is reset asynchronously with the FSM so a reset mid-run always
  // reports a clean zero; it saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCount <= '0;
    end else if (!ctrl.pcWrite && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

  assign pc_sel      = ctrl.pcSel;
  assign pc_write    = ctrl.pcWrite;
  assign ifid_write  = ctrl.ifidWrite;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_flush  = ctrl.idexFlush;
  assign stall_count = stallCount;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl. Two instances share the stimulus: dut uses
// FLUSH_CYCLES=1, dut3 uses FLUSH_CYCLES=3. Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_jump;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;

  logic [1:0]  pcSel1, pcSel3;
  logic        pcWrite1, pcWrite3;
  logic        ifidWrite1, ifidWrite3;
  logic        ifidFlush1, ifidFlush3;
  logic        idexFlush1, idexFlush3;
  logic [15:0] stallCount1, stallCount3;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .pc_sel(pcSel1), .pc_write(pcWrite1), .ifid_write(ifidWrite1),
    .ifid_flush(ifidFlush1), .idex_flush(idexFlush1), .stall_count(stallCount1)
  );

  pc_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .pc_sel(pcSel3), .pc_write(pcWrite3), .ifid_write(ifidWrite3),
    .ifid_flush(ifidFlush3), .idex_flush(idexFlush3), .stall_count(stallCount3)
  );

  typedef struct packed {
    logic        rdy;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usesRt;
    logic        jump;
    logic        memread;
    logic [4:0]  rd;
    logic        br;
    logic [1:0]  sel;
    logic        pw;
    logic        iw;
    logic        ifl;
    logic        idf;
    logic        iwCare;  // 0 where ifid_write is not defined (flush overrides it)
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rdy, input logic [4:0] rs, input logic [4:0] rt,
                              input logic usesRt, input logic jump, input logic memread,
                              input logic [4:0] rd, input logic br, input logic [1:0] sel,
                              input logic pw, input logic iw, input logic ifl,
                              input logic idf, input logic iwCare, input logic [15:0] cnt);
    vec_t v;
    v = '{rdy: rdy, rs: rs, rt: rt, usesRt: usesRt, jump: jump, memread: memread, rd: rd,
          br: br, sel: sel, pw: pw, iw: iw, ifl: ifl, idf: idf, iwCare: iwCare, cnt: cnt};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [4:0] rs, input logic [4:0] rt,
                       input logic usesRt, input logic jump, input logic memread,
                       input logic [4:0] rd, input logic br);
    imem_ready      = rdy;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = usesRt;
    id_jump         = jump;
    ex_memread      = memread;
    ex_rd           = rd;
    ex_branch_taken = br;
  endtask

  task automatic idle(input logic rdy);
    drive(rdy, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic checkDut(input string tag, input logic [1:0] sel, input logic pw,
                          input logic ifl, input logic idf, input logic [15:0] cnt);
    check({tag, " pc_sel"},      32'(pcSel1),      32'(sel));
    check({tag, " pc_write"},    32'(pcWrite1),    32'(pw));
    check({tag, " ifid_flush"},  32'(ifidFlush1),  32'(ifl));
    check({tag, " idex_flush"},  32'(idexFlush1),  32'(idf));
    check({tag, " stall_count"}, 32'(stallCount1), 32'(cnt));
  endtask

  task automatic checkDut3(input string tag, input logic [1:0] sel, input logic pw,
                           input logic ifl, input logic idf);
    check({tag, " fc3 pc_sel"},     32'(pcSel3),     32'(sel));
    check({tag, " fc3 pc_write"},   32'(pcWrite3),   32'(pw));
    check({tag, " fc3 ifid_flush"}, 32'(ifidFlush3), 32'(ifl));
    check({tag, " fc3 idex_flush"}, 32'(idexFlush3), 32'(idf));
  endtask

  task automatic checkReset(input string tag);
    checkDut(tag, 2'd0, 1'b0, 1'b1, 1'b1, 16'd0);
    check({tag, " ifid_write"}, 32'(ifidWrite1), 32'd0);
    checkDut3(tag, 2'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input string tag);
    reset_n = 1'b0;
    idle(1'b1);
    @(negedge clk);
    checkReset(tag);
    nextCycle();
    reset_n = 1'b1;
  endtask

  initial begin
    //            rdy rs    rt    uRt  jmp  mrd  rd    br    sel   pw   iw   ifl  idf  iwC  cnt
    vecs[0]  = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd0);
    vecs[1]  = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd0);
    vecs[2]  = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd0);
    vecs[3]  = mk(1, 5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 2'd0, 0, 0, 0, 1, 1, 16'd0);  // LU on rs
    vecs[4]  = mk(1, 5'd5, 5'd0, 0, 0, 0, 5'd5, 0, 2'd0, 1, 1, 0, 0, 1, 16'd1);
    vecs[5]  = mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd1);  // rd=0
    vecs[6]  = mk(1, 5'd3, 5'd7, 1, 0, 1, 5'd7, 0, 2'd0, 0, 0, 0, 1, 1, 16'd1);  // LU on rt
    vecs[7]  = mk(1, 5'd3, 5'd7, 0, 0, 1, 5'd7, 0, 2'd0, 1, 1, 0, 0, 1, 16'd2);  // rt unused
    vecs[8]  = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 1, 1, 16'd2);  // imem wait
    vecs[9]  = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd3);
    vecs[10] = mk(1, 5'd0, 5'd0, 0, 1, 0, 5'd0, 1, 2'd1, 1, 0, 1, 1, 0, 16'd3);  // BR+JMP
    vecs[11] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd3);
    vecs[12] = mk(1, 5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 2'd2, 1, 0, 1, 0, 0, 16'd3);  // JMP
    vecs[13] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd3);
    vecs[14] = mk(1, 5'd5, 5'd0, 0, 0, 1, 5'd5, 1, 2'd1, 1, 0, 1, 1, 0, 16'd3);  // BR+LU
    vecs[15] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd3);
    vecs[16] = mk(0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 2'd2, 0, 0, 0, 1, 1, 16'd3);  // JMP, wait
    vecs[17] = mk(0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 2'd2, 0, 0, 0, 1, 1, 16'd4);
    vecs[18] = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 2'd2, 0, 0, 0, 1, 1, 16'd5);  // BR ignored
    vecs[19] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd2, 1, 0, 1, 1, 1, 16'd6);  // accepted
    vecs[20] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd6);
    vecs[21] = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 2'd1, 0, 0, 0, 1, 1, 16'd6);  // BR, wait
    vecs[22] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd1, 1, 0, 1, 1, 1, 16'd7);
    vecs[23] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 0, 0, 1, 16'd7);

    // Reset held for 3 cycles with imem_ready already high.
    reset_n = 1'b0;
    idle(1'b1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkReset("reset");
    nextCycle();
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rdy, vecs[i].rs, vecs[i].rt, vecs[i].usesRt, vecs[i].jump,
            vecs[i].memread, vecs[i].rd, vecs[i].br);
      @(negedge clk);
      checkDut($sformatf("v%0d", i), vecs[i].sel, vecs[i].pw, vecs[i].ifl, vecs[i].idf,
               vecs[i].cnt);
      if (vecs[i].iwCare) begin
        check($sformatf("v%0d ifid_write", i), 32'(ifidWrite1), 32'(vecs[i].iw));
      end
      nextCycle();
    end

    // FLUSH_CYCLES=3: branch, then two more flush cycles; jumps seen there are ignored
    // and an imem wait state inside FLUSH holds the count.
    pulseReset("reset2");
    idle(1'b1);
    @(negedge clk);
    checkDut3("f0 idle", 2'd0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checkDut3("f1 br", 2'd1, 1'b1, 1'b1, 1'b1);
    nextCycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkDut3("f2 jmp", 2'd0, 1'b1, 1'b1, 1'b1);
    nextCycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkDut3("f2w jmp", 2'd0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkDut3("f3 jmp", 2'd0, 1'b1, 1'b1, 1'b1);
    nextCycle();
    idle(1'b1);
    @(negedge clk);
    checkDut3("f4 run", 2'd0, 1'b1, 1'b0, 1'b0);
    nextCycle();

    // Saturation: 2^16+5 wait-state cycles in RUN.
    pulseReset("reset3");
    idle(1'b0);
    repeat (65536 + 5) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat stall_count", 32'(stallCount1), 32'h0000_FFFF);
    check("sat fc3 stall_count", 32'(stallCount3), 32'h0000_FFFF);
    nextCycle();

    // Enter WAIT with a pending jump, then reset in the middle of the cycle.
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    nextCycle();
    idle(1'b0);
    #2;
    check("wait pc_sel", 32'(pcSel1), 32'd2);
    reset_n = 1'b0;
    #1;
    checkReset("midwait reset");
    nextCycle();
    reset_n = 1'b1;
    idle(1'b1);
    @(negedge clk);
    checkDut("post reset", 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    nextCycle();
    @(negedge clk);
    checkDut("post reset2", 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
